hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_fwd_unit.sv | 186 ++++++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: EXE operand forwarding selects, load-use stall and
// redirect flush control. Define HAZARD_PERF_EN to add stall/flush counters.

`ifndef ASIZE
`define ASIZE 5
`endif

module hazard_fwd_unit (
  input  logic              clk,
  input  logic              rst,
  input  logic [`ASIZE-1:0] id_rs,
  input  logic [`ASIZE-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [`ASIZE-1:0] ex_rs,
  input  logic [`ASIZE-1:0] ex_rt,
  input  logic [`ASIZE-1:0] idex_waddr,
  input  logic              idex_memRead,
  input  logic [`ASIZE-1:0] exmem_waddr,
  input  logic              exmem_wen,
  input  logic [`ASIZE-1:0] memwb_waddr,
  input  logic              memwb_wen,
  input  logic              ex_redirect,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
`ifdef HAZARD_PERF_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: none. Every control output is a same-cycle (Mealy) function of
  // the current inputs and state; the pipeline samples them on the next edge.

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  state_e state_q;
  state_e state_d;
  logic   load_use;

  // ---------------------------------------------------------------------------
  // Forwarding: purely combinational, independent of rst and FSM state.
  // The youngest producer (EX/MEM) wins over MEM/WB.
  // ---------------------------------------------------------------------------
  logic exmem_hit_a;
  logic exmem_hit_b;
  logic memwb_hit_a;
  logic memwb_hit_b;

  always_comb begin
    exmem_hit_a = exmem_wen && (exmem_waddr != '0) && (exmem_waddr == ex_rs);
    exmem_hit_b = exmem_wen && (exmem_waddr != '0) && (exmem_waddr == ex_rt);
    memwb_hit_a = memwb_wen && (memwb_waddr != '0) && (memwb_waddr == ex_rs);
    memwb_hit_b = memwb_wen && (memwb_waddr != '0) && (memwb_waddr == ex_rt);
  end

  always_comb begin
    fwd_a = FWD_RF;
    if (exmem_hit_a) begin
      fwd_a = FWD_EXMEM;
    end else if (memwb_hit_a) begin
      fwd_a = FWD_MEMWB;
    end
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (exmem_hit_b) begin
      fwd_b = FWD_EXMEM;
    end else if (memwb_hit_b) begin
      fwd_b = FWD_MEMWB;
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use detection: the load in EXE writes a register the ID instruction
  // reads. r0 never creates a dependency.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_use = idex_memRead && (idex_waddr != '0) &&
               ((idex_waddr == id_rs) || (id_uses_rt && (idex_waddr == id_rt)));
  end

  // ---------------------------------------------------------------------------
  // Control FSM. LDSTALL and FLUSH are single-cycle shadows in which EXE
  // already holds a bubble, so nothing is re-detected there.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    if (rst) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = ST_FLUSH;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = ST_LDSTALL;
          end
        end
        ST_LDSTALL: begin
          state_d = ST_RUN;
        end
        ST_FLUSH: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign dbg_state = state_q;

`ifdef HAZARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Event counters: count entries into the stall/flush states, saturating.
  // ---------------------------------------------------------------------------
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;
  logic [15:0] flush_cnt_q;
  logic [15:0] flush_cnt_d;
  logic        enter_stall;
  logic        enter_flush;

  always_comb begin
    enter_stall = !rst && (state_q == ST_RUN) && (state_d == ST_LDSTALL);
    enter_flush = !rst && (state_q == ST_RUN) && (state_d == ST_FLUSH);

    stall_cnt_d = stall_cnt_q;
    if (enter_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    flush_cnt_d = flush_cnt_q;
    if (enter_flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit with a scoreboard queue and an
// independent negedge monitor. Counter checks are active under HAZARD_PERF_EN.

`ifndef ASIZE
`define ASIZE 5
`endif

module tb_hazard_fwd_unit;

  logic              clk;
  logic              rst;
  logic [`ASIZE-1:0] id_rs;
  logic [`ASIZE-1:0] id_rt;
  logic              id_uses_rt;
  logic [`ASIZE-1:0] ex_rs;
  logic [`ASIZE-1:0] ex_rt;
  logic [`ASIZE-1:0] idex_waddr;
  logic              idex_memRead;
  logic [`ASIZE-1:0] exmem_waddr;
  logic              exmem_wen;
  logic [`ASIZE-1:0] memwb_waddr;
  logic              memwb_wen;
  logic              ex_redirect;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
`ifdef HAZARD_PERF_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;
`endif
  logic [1:0]        dbg_state;

  hazard_fwd_unit dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .idex_waddr   (idex_waddr),
    .idex_memRead (idex_memRead),
    .exmem_waddr  (exmem_waddr),
    .exmem_wen    (exmem_wen),
    .memwb_waddr  (memwb_waddr),
    .memwb_wen    (memwb_wen),
    .ex_redirect  (ex_redirect),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
`ifdef HAZARD_PERF_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [31:0] cnt_q[$];
  string       name_q[$];
  logic        chk_valid;
  int          n_cmp;
  int          n_err;

  function automatic logic [7:0] ctl(input logic pw, input logic iw, input logic fl,
                                     input logic bb, input logic [1:0] fa,
                                     input logic [1:0] fb);
    return {pw, iw, fl, bb, fa, fb};
  endfunction

  // Monitor: one check per flagged cycle, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL underflow: monitor saw a check cycle with no expected entry");
      end else begin
        logic [7:0]  e;
        logic [7:0]  a;
        logic [31:0] ec;
        string       nm;
        e  = exp_q.pop_front();
        ec = cnt_q.pop_front();
        nm = name_q.pop_front();
        a  = {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s ctrl: got pw/iw/fl/bb/fa/fb=%b required %b", nm, a, e);
        end
`ifdef HAZARD_PERF_EN
        n_cmp++;
        if ({stall_cnt, flush_cnt} !== ec) begin
          n_err++;
          $display("FAIL %s cnt: got stall=%h flush=%h required stall=%h flush=%h",
                   nm, stall_cnt, flush_cnt, ec[31:16], ec[15:0]);
        end
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_rs        = '0;
    id_rt        = '0;
    id_uses_rt   = 1'b0;
    ex_rs        = '0;
    ex_rt        = '0;
    idex_waddr   = '0;
    idex_memRead = 1'b0;
    exmem_waddr  = '0;
    exmem_wen    = 1'b0;
    memwb_waddr  = '0;
    memwb_wen    = 1'b0;
    ex_redirect  = 1'b0;
  endtask

  // Inputs are already applied; optionally queue the expectation, then advance
  // one cycle. The monitor's negedge falls inside this cycle.
  task automatic cyc(input string nm, input logic chk, input logic [7:0] e,
                     input logic [15:0] es, input logic [15:0] ef);
    chk_valid = chk;
    if (chk) begin
      exp_q.push_back(e);
      cnt_q.push_back({es, ef});
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_hazard_rs();
    idex_memRead = 1'b1;
    idex_waddr   = 5'd5;
    id_rs        = 5'd5;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp     = 0;
    n_err     = 0;
    chk_valid = 1'b0;
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset overrides hazard and redirect; forwarding still live.
    load_hazard_rs();
    ex_redirect = 1'b1;
    exmem_wen = 1'b1; exmem_waddr = 5'd3; ex_rs = 5'd3;
    cyc("reset_ovr", 1'b1, ctl(1, 1, 0, 0, 2'b10, 2'b00), 16'd0, 16'd0);

    rst = 1'b0;
    set_idle();
    exmem_wen = 1'b1; exmem_waddr = 5'd3; memwb_wen = 1'b1; memwb_waddr = 5'd3;
    ex_rs = 5'd3; ex_rt = 5'd3;
    cyc("fwd_exmem_prio", 1'b1, ctl(1, 1, 0, 0, 2'b10, 2'b10), 16'd0, 16'd0);

    set_idle();
    exmem_wen = 1'b0; exmem_waddr = 5'd4; memwb_wen = 1'b1; memwb_waddr = 5'd4;
    ex_rs = 5'd4; ex_rt = 5'd7;
    cyc("fwd_memwb_a", 1'b1, ctl(1, 1, 0, 0, 2'b01, 2'b00), 16'd0, 16'd0);

    set_idle();
    exmem_wen = 1'b1; exmem_waddr = 5'd0; memwb_wen = 1'b1; memwb_waddr = 5'd0;
    ex_rs = 5'd0; ex_rt = 5'd0;
    cyc("fwd_r0", 1'b1, ctl(1, 1, 0, 0, 2'b00, 2'b00), 16'd0, 16'd0);

    set_idle();
    exmem_wen = 1'b0; exmem_waddr = 5'd6; memwb_wen = 1'b1; memwb_waddr = 5'd6;
    ex_rt = 5'd6;
    cyc("fwd_memwb_b", 1'b1, ctl(1, 1, 0, 0, 2'b00, 2'b01), 16'd0, 16'd0);

    // Load-use through rt: one stall cycle, redirect ignored in LDSTALL.
    set_idle();
    idex_memRead = 1'b1; idex_waddr = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1; id_rs = 5'd1;
    cyc("ldstall_rt", 1'b1, ctl(0, 0, 0, 1, 2'b00, 2'b00), 16'd0, 16'd0);
    ex_redirect = 1'b1;
    cyc("ldstall_done", 1'b1, ctl(1, 1, 0, 0, 2'b00, 2'b00), 16'd1, 16'd0);
    ex_redirect = 1'b0; id_uses_rt = 1'b0;
    cyc("no_uses_rt", 1'b1, ctl(1, 1, 0, 0, 2'b00, 2'b00), 16'd1, 16'd0);

    set_idle();
    idex_memRead = 1'b1; idex_waddr = 5'd0; id_rs = 5'd0;
    cyc("load_r0", 1'b1, ctl(1, 1, 0, 0, 2'b00, 2'b00), 16'd1, 16'd0);

    // Redirect beats load-use; FLUSH ignores both.
    set_idle();
    load_hazard_rs();
    ex_redirect = 1'b1;
    cyc("redirect_prio", 1'b1, ctl(1, 1, 1, 1, 2'b00, 2'b00), 16'd1, 16'd0);
    cyc("flush_hold", 1'b1, ctl(1, 1, 0, 0, 2'b00, 2'b00), 16'd1, 16'd1);
    cyc("redirect_again", 1'b1, ctl(1, 1, 1, 1, 2'b00, 2'b00), 16'd1, 16'd1);
    ex_redirect = 1'b0;
    cyc("flush_ign_lu", 1'b1, ctl(1, 1, 0, 0, 2'b00, 2'b00), 16'd1, 16'd2);
    cyc("ldstall_rs", 1'b1, ctl(0, 0, 0, 1, 2'b00, 2'b00), 16'd1, 16'd2);

    // Reset inside LDSTALL: back to RUN with counters cleared.
    rst = 1'b1;
    cyc("rst_in_ldstall", 1'b1, ctl(1, 1, 0, 0, 2'b00, 2'b00), 16'd2, 16'd2);
    rst = 1'b0;
    cyc("run_after_rst", 1'b1, ctl(0, 0, 0, 1, 2'b00, 2'b00), 16'd0, 16'd0);
    set_idle();
    cyc("idle_ldstall", 1'b1, ctl(1, 1, 0, 0, 2'b00, 2'b00), 16'd1, 16'd0);

    // Reset inside FLUSH.
    ex_redirect = 1'b1;
    cyc("redirect_2", 1'b1, ctl(1, 1, 1, 1, 2'b00, 2'b00), 16'd1, 16'd0);
    rst = 1'b1;
    cyc("rst_in_flush", 1'b1, ctl(1, 1, 0, 0, 2'b00, 2'b00), 16'd1, 16'd1);
    rst = 1'b0;
    cyc("run_after_rst2", 1'b1, ctl(1, 1, 1, 1, 2'b00, 2'b00), 16'd0, 16'd0);
    set_idle();
    cyc("idle_flush", 1'b1, ctl(1, 1, 0, 0, 2'b00, 2'b00), 16'd0, 16'd1);

`ifdef HAZARD_PERF_EN
    // Flush counter saturation: 65540 further redirects on top of the one above.
    for (int i = 0; i < 65540; i++) begin
      ex_redirect = 1'b1;
      cyc("sat_redirect", 1'b0, 8'h00, 16'd0, 16'd0);
      ex_redirect = 1'b0;
      cyc("sat_idle", 1'b0, 8'h00, 16'd0, 16'd0);
    end
    cyc("flush_sat", 1'b1, ctl(1, 1, 0, 0, 2'b00, 2'b00), 16'd0, 16'hFFFF);
`endif

    chk_valid = 1'b0;
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
